// File: rtl/dsp48a1_valid_track_if.sv
// Control/status bundle between the DSP48A1 datapath sequencer and its valid tracker.
// in_valid is a pure strobe with no ready: an operation counts as accepted only on a
// rising edge with ce=1 and flush=0; out_valid marks the cycle in which P carries it.
interface dsp48a1_valid_track_if;
  logic        ce;
  logic        in_valid;
  logic        flush;
  logic        out_valid;
  logic [2:0]  inflight;
  logic        busy;
  logic [15:0] result_cnt;
  logic        path_skew;

  modport master (
    output ce, in_valid, flush,
    input  out_valid, inflight, busy, result_cnt, path_skew
  );

  modport slave (
    input  ce, in_valid, flush,
    output out_valid, inflight, busy, result_cnt, path_skew
  );
endinterface

// File: rtl/dsp48a1_valid_track.sv
// Valid-bit delay line matched to the DSP48A1 register configuration, with
// occupancy, saturating result count and a constant operand-skew flag.
module dsp48a1_valid_track #(
  parameter int A0REG = 0,
  parameter int A1REG = 1,
  parameter int B0REG = 0,
  parameter int B1REG = 1,
  parameter int DREG  = 1,
  parameter int CREG  = 1,
  parameter int MREG  = 1,
  parameter int PREG  = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  dsp48a1_valid_track_if.slave  vt
);

  localparam int LA   = A0REG + A1REG;
  localparam int LB   = ((B0REG > DREG) ? B0REG : DREG) + B1REG;
  localparam int LM   = ((LA > LB) ? LA : LB) + MREG;
  localparam int L    = ((LM > CREG) ? LM : CREG) + PREG;
  localparam bit SKEW = (LA != LB) || (CREG != 0 && CREG != LM);

  logic        ov;
  logic [2:0]  inflight;
  logic [15:0] cnt;

  function automatic logic [2:0] popcnt(input logic [3:0] v);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 4; i++) s = s + {2'b00, v[i]};
    return s;
  endfunction

  generate
    if (L == 0) begin : g_bypass
      // Fully bypassed datapath: P reflects the operands in the same cycle.
      assign ov       = vt.in_valid & vt.ce;
      assign inflight = 3'd0;
    end else begin : g_line
      logic [L-1:0] vl;
      logic [L-1:0] vl_next;

      always_comb begin
        vl_next = vl;
        if (vt.flush) begin
          vl_next = '0;
        end else if (vt.ce) begin
          vl_next[0] = vt.in_valid;
          for (int i = 1; i < L; i++) vl_next[i] = vl[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vl       <= '0;
          inflight <= 3'd0;
        end else begin
          vl       <= vl_next;
          inflight <= popcnt(4'(vl_next));
        end
      end

      assign ov = vl[L-1];
    end
  endgenerate

  // A result is consumed on the ce edge that ends its out_valid cycle, so a
  // stalled result is counted once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 16'd0;
    end else if (vt.ce && ov && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign vt.out_valid  = ov;
  assign vt.inflight   = inflight;
  assign vt.busy       = (inflight != 3'd0);
  assign vt.result_cnt = cnt;
  assign vt.path_skew  = SKEW;

endmodule

// File: tb/tb_dsp48a1_valid_track.sv
// Bench for dsp48a1_valid_track: four configurations (L=3,4,0,2) share one stimulus
// stream; a fifth L=3 instance runs the counter into saturation alongside.
module tb_dsp48a1_valid_track;

  logic clk;
  logic rst_n, ce, in_valid, flush;
  logic sat_rst_n, sat_ce, sat_iv;
  logic sat_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Latency and skew worked out by hand from the parameter sets below.
  int lat [4]  = '{3, 4, 0, 2};
  int skew[4]  = '{0, 1, 0, 1};

  dsp48a1_valid_track_if if_a ();
  dsp48a1_valid_track_if if_b ();
  dsp48a1_valid_track_if if_z ();
  dsp48a1_valid_track_if if_s ();
  dsp48a1_valid_track_if if_sat ();

  assign if_a.ce = ce;  assign if_a.in_valid = in_valid;  assign if_a.flush = flush;
  assign if_b.ce = ce;  assign if_b.in_valid = in_valid;  assign if_b.flush = flush;
  assign if_z.ce = ce;  assign if_z.in_valid = in_valid;  assign if_z.flush = flush;
  assign if_s.ce = ce;  assign if_s.in_valid = in_valid;  assign if_s.flush = flush;
  assign if_sat.ce = sat_ce;  assign if_sat.in_valid = sat_iv;  assign if_sat.flush = 1'b0;

  // L=3, no skew: LA=1, LB=1, LM=2, C bypassed
  dsp48a1_valid_track #(.A0REG(0), .A1REG(1), .B0REG(0), .B1REG(1), .DREG(0), .CREG(0), .MREG(1), .PREG(1))
    u_a (.clk(clk), .rst_n(rst_n), .vt(if_a.slave));
  // L=4, skew from CREG=1 vs LM=3
  dsp48a1_valid_track #(.A0REG(1), .A1REG(1), .B0REG(1), .B1REG(1), .DREG(1), .CREG(1), .MREG(1), .PREG(1))
    u_b (.clk(clk), .rst_n(rst_n), .vt(if_b.slave));
  // L=0, fully bypassed
  dsp48a1_valid_track #(.A0REG(0), .A1REG(0), .B0REG(0), .B1REG(0), .DREG(0), .CREG(0), .MREG(0), .PREG(0))
    u_z (.clk(clk), .rst_n(rst_n), .vt(if_z.slave));
  // L=2, skew from LA=1 vs LB=0
  dsp48a1_valid_track #(.A0REG(0), .A1REG(1), .B0REG(0), .B1REG(0), .DREG(0), .CREG(0), .MREG(0), .PREG(1))
    u_s (.clk(clk), .rst_n(rst_n), .vt(if_s.slave));
  dsp48a1_valid_track #(.A0REG(0), .A1REG(1), .B0REG(0), .B1REG(1), .DREG(0), .CREG(0), .MREG(1), .PREG(1))
    u_sat (.clk(clk), .rst_n(sat_rst_n), .vt(if_sat.slave));

  logic        ov_w  [4];
  logic [2:0]  inf_w [4];
  logic        busy_w[4];
  logic [15:0] cnt_w [4];
  logic        skew_w[4];

  assign ov_w[0] = if_a.out_valid; assign inf_w[0] = if_a.inflight; assign busy_w[0] = if_a.busy;
  assign cnt_w[0] = if_a.result_cnt; assign skew_w[0] = if_a.path_skew;
  assign ov_w[1] = if_b.out_valid; assign inf_w[1] = if_b.inflight; assign busy_w[1] = if_b.busy;
  assign cnt_w[1] = if_b.result_cnt; assign skew_w[1] = if_b.path_skew;
  assign ov_w[2] = if_z.out_valid; assign inf_w[2] = if_z.inflight; assign busy_w[2] = if_z.busy;
  assign cnt_w[2] = if_z.result_cnt; assign skew_w[2] = if_z.path_skew;
  assign ov_w[3] = if_s.out_valid; assign inf_w[3] = if_s.inflight; assign busy_w[3] = if_s.busy;
  assign cnt_w[3] = if_s.result_cnt; assign skew_w[3] = if_s.path_skew;

  // ---------------- clock/reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted operation is remembered by the number of the
  // ce edge that captured it; it is on P once L-1 further ce edges have passed.
  typedef struct { int k; int idx; } op_t;
  op_t         ops[$];
  int          ce_idx = 0;
  int unsigned mcnt[4] = '{0, 0, 0, 0};
  bit          model_on = 0;

  function automatic logic m_ov(input int k);
    if (lat[k] == 0) return in_valid & ce;
    foreach (ops[i]) if (ops[i].k == k && ce_idx - ops[i].idx == lat[k] - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_inf(input int k);
    int n = 0;
    foreach (ops[i]) if (ops[i].k == k) n++;
    return n;
  endfunction

  task automatic model_check();
    for (int k = 0; k < 4; k++) begin
      cmp($sformatf("out_valid[%0d]", k),  32'(ov_w[k]),   32'(m_ov(k)));
      cmp($sformatf("inflight[%0d]", k),   32'(inf_w[k]),  32'(m_inf(k)));
      cmp($sformatf("busy[%0d]", k),       32'(busy_w[k]), 32'(m_inf(k) != 0));
      cmp($sformatf("result_cnt[%0d]", k), 32'(cnt_w[k]),  32'(mcnt[k]));
    end
  endtask

  task automatic model_edge();
    logic ov[4];
    op_t  keep[$];
    for (int k = 0; k < 4; k++) ov[k] = m_ov(k);
    if (!rst_n) begin
      ops.delete();
      for (int k = 0; k < 4; k++) mcnt[k] = 0;
    end else begin
      for (int k = 0; k < 4; k++) if (ce && ov[k] && mcnt[k] < 65535) mcnt[k]++;
      if (flush) begin
        ops.delete();
      end else if (ce) begin
        ce_idx++;
        for (int k = 0; k < 4; k++) if (in_valid && lat[k] > 0) ops.push_back('{k, ce_idx});
        foreach (ops[i]) if (ce_idx - ops[i].idx < lat[ops[i].k]) keep.push_back(ops[i]);
        ops = keep;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic r, input logic c, input logic v, input logic f);
    @(negedge clk);
    rst_n = r; ce = c; in_valid = v; flush = f;
    #1;
    if (model_on) model_check();
    model_edge();
  endtask

  // Directed vectors for the L=3 instance; expectations are the values seen
  // in that cycle, before its rising edge.
  typedef struct {
    logic r, c, v, f;
    logic chk;
    logic ov;
    logic [2:0] inf;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[30];

  initial begin
    rst_n = 1'b0; ce = 1'b0; in_valid = 1'b0; flush = 1'b0;

    //          r  c  v  f  chk ov inf cnt
    tbl[0]  = '{0, 1, 1, 0, 0, 0, 0, 0};   // reset
    tbl[1]  = '{1, 1, 0, 0, 1, 0, 0, 0};   // reset state
    tbl[2]  = '{1, 1, 1, 0, 1, 0, 0, 0};   // single pulse accepted
    tbl[3]  = '{1, 1, 0, 0, 1, 0, 1, 0};
    tbl[4]  = '{1, 1, 0, 0, 1, 0, 1, 0};
    tbl[5]  = '{1, 1, 0, 0, 1, 1, 1, 0};   // on P
    tbl[6]  = '{1, 1, 0, 0, 1, 0, 0, 1};
    tbl[7]  = '{1, 1, 1, 0, 1, 0, 0, 1};   // pulse for stall test
    tbl[8]  = '{1, 1, 0, 0, 1, 0, 1, 1};   // now in vl[1] after edge
    tbl[9]  = '{1, 0, 1, 0, 1, 0, 1, 1};   // stall; in_valid ignored
    tbl[10] = '{1, 0, 0, 0, 1, 0, 1, 1};
    tbl[11] = '{1, 0, 0, 0, 1, 0, 1, 1};
    tbl[12] = '{1, 0, 1, 0, 1, 0, 1, 1};
    tbl[13] = '{1, 1, 0, 0, 1, 0, 1, 1};
    tbl[14] = '{1, 0, 0, 0, 1, 1, 1, 1};   // out_valid held through stall
    tbl[15] = '{1, 0, 0, 0, 1, 1, 1, 1};
    tbl[16] = '{1, 1, 0, 0, 1, 1, 1, 1};   // counted once here
    tbl[17] = '{1, 1, 0, 0, 1, 0, 0, 2};
    tbl[18] = '{1, 1, 1, 0, 1, 0, 0, 2};   // flush sequence
    tbl[19] = '{1, 1, 1, 0, 1, 0, 1, 2};
    tbl[20] = '{1, 1, 1, 1, 1, 0, 2, 2};   // flush with in_valid
    tbl[21] = '{1, 1, 0, 0, 1, 0, 0, 2};
    tbl[22] = '{1, 1, 0, 0, 1, 0, 0, 2};
    tbl[23] = '{1, 1, 0, 0, 1, 0, 0, 2};
    tbl[24] = '{1, 1, 1, 0, 1, 0, 0, 2};   // reset mid-flight
    tbl[25] = '{1, 1, 1, 0, 1, 0, 1, 2};
    tbl[26] = '{0, 1, 1, 0, 1, 0, 2, 2};
    tbl[27] = '{1, 1, 0, 0, 1, 0, 0, 0};
    tbl[28] = '{1, 1, 0, 0, 1, 0, 0, 0};
    tbl[29] = '{1, 1, 0, 0, 1, 0, 0, 0};

    for (int k = 0; k < 4; k++) cmp($sformatf("path_skew[%0d]", k), 32'(skew_w[k]), 32'(skew[k]));

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rst_n = tbl[i].r; ce = tbl[i].c; in_valid = tbl[i].v; flush = tbl[i].f;
      #1;
      if (tbl[i].chk) begin
        cmp($sformatf("vec%0d out_valid", i),  32'(if_a.out_valid),  32'(tbl[i].ov));
        cmp($sformatf("vec%0d inflight", i),   32'(if_a.inflight),   32'(tbl[i].inf));
        cmp($sformatf("vec%0d busy", i),       32'(if_a.busy),       32'(tbl[i].inf != 3'd0));
        cmp($sformatf("vec%0d result_cnt", i), 32'(if_a.result_cnt), 32'(tbl[i].cnt));
      end
      if (model_on) model_check();
      model_edge();
      model_on = 1;
    end

    // Back-to-back burst of 10 at full rate, then drain.
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 1'b1, i < 10, 1'b0);

    // Randomized traffic with stalls, flushes and occasional resets.
    for (int i = 0; i < 400; i++)
      drive_cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);

    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);

    wait (sat_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Saturation run on its own instance: one result per cycle after the first three.
  initial begin
    sat_done = 1'b0; sat_rst_n = 1'b0; sat_ce = 1'b1; sat_iv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sat_rst_n = 1'b1; sat_iv = 1'b1;
    for (int n = 1; n <= 65545; n++) begin
      @(posedge clk);
      #1;
      if (n == 3 || n == 4 || n == 65537 || n == 65540 || n == 65545)
        cmp($sformatf("sat cnt after edge %0d", n), 32'(if_sat.result_cnt),
            (n - 3 > 65535) ? 32'd65535 : 32'(n - 3));
      if (n == 10) begin
        cmp("sat inflight full", 32'(if_sat.inflight), 32'd3);
        cmp("sat out_valid", 32'(if_sat.out_valid), 32'd1);
      end
    end
    sat_done = 1'b1;
  end

endmodule
